// File: rtl/adder_defs.sv
// Shared definitions for the serial operand loader: FSM state encodings,
// default operand width and bit-counter width.
package adder_defs;

    localparam int LOADER_WIDTH_DEFAULT = 3;
    // Counter must index bits 0..7 for the widest legal operand.
    localparam int CNT_WIDTH = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_LOAD_B  = 3'd2,
        ST_LOAD_C  = 3'd3,
        ST_PRESENT = 3'd4
    } state_t;

    function automatic logic state_is_busy(input state_t st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/serial_operand_loader_if.sv
// Handshake/operand bundle between a serial source, the loader and the
// downstream adder. The loader takes the slave view.
interface serial_operand_loader_if
    import adder_defs::*;
#(
    parameter int WIDTH = LOADER_WIDTH_DEFAULT
);
    logic             start;
    logic             abort;
    logic             sdata;
    logic             sdata_valid;
    logic             op_ack;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op_valid;
    logic             busy;

    modport master (
        output start, abort, sdata, sdata_valid, op_ack,
        input  a, b, cin, op_valid, busy
    );

    modport slave (
        input  start, abort, sdata, sdata_valid, op_ack,
        output a, b, cin, op_valid, busy
    );
endinterface

// File: rtl/sipo_shift.sv
// Serial-in/parallel-out operand register: writes one serial bit at the
// position given by idx when enabled; clr zeroes the whole register.
module sipo_shift
    import adder_defs::*;
#(
    parameter int WIDTH = LOADER_WIDTH_DEFAULT
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] idx,
    input  logic                 din,
    output logic [WIDTH-1:0]     q
);

    // Operand storage; clear has priority over a bit write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (idx == CNT_WIDTH'(i)) begin
                    q[i] <= din;
                end
            end
        end
    end

endmodule

// File: rtl/serial_operand_loader.sv
// Loads operands A, B (and optionally carry-in, with SERIAL_CIN_LOAD_EN
// defined) LSB-first from a serial stream and presents them to an adder.
module serial_operand_loader
    import adder_defs::*;
#(
    parameter int WIDTH = LOADER_WIDTH_DEFAULT
)(
    input  logic                   clk,
    input  logic                   rst_n,
    serial_operand_loader_if.slave bus
);

    state_t                 state_r;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic                   cin_r;
    logic                   op_valid_r;
    logic                   busy_r;

    logic                   clr_s;
    logic                   en_a_s;
    logic                   en_b_s;
    logic                   last_s;

    assign last_s = (cnt_r == CNT_WIDTH'(WIDTH - 1));

    // Operand register controls; abort suppresses every write.
    always_comb begin
        clr_s  = 1'b0;
        en_a_s = 1'b0;
        en_b_s = 1'b0;
        if (bus.abort) begin
            clr_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:    clr_s  = bus.start;
                ST_LOAD_A:  en_a_s = bus.sdata_valid;
                ST_LOAD_B:  en_b_s = bus.sdata_valid;
                default:    clr_s  = 1'b0;
            endcase
        end
    end

    sipo_shift #(.WIDTH(WIDTH)) u_sipo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .en    (en_a_s),
        .idx   (cnt_r),
        .din   (bus.sdata),
        .q     (bus.a)
    );

    sipo_shift #(.WIDTH(WIDTH)) u_sipo_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .en    (en_b_s),
        .idx   (cnt_r),
        .din   (bus.sdata),
        .q     (bus.b)
    );

    // Loader FSM with registered op_valid/busy; abort overrides all inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            cin_r      <= 1'b0;
            op_valid_r <= 1'b0;
            busy_r     <= 1'b0;
        end else if (bus.abort) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            op_valid_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        cnt_r   <= '0;
                        cin_r   <= 1'b0;
                        state_r <= ST_LOAD_A;
                        busy_r  <= state_is_busy(ST_LOAD_A);
                    end
                end
                ST_LOAD_A: begin
                    if (bus.sdata_valid) begin
                        if (last_s) begin
                            cnt_r   <= '0;
                            state_r <= ST_LOAD_B;
                        end else begin
                            cnt_r   <= cnt_r + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (bus.sdata_valid) begin
                        if (last_s) begin
                            cnt_r      <= '0;
`ifdef SERIAL_CIN_LOAD_EN
                            state_r    <= ST_LOAD_C;
`else
                            state_r    <= ST_PRESENT;
                            op_valid_r <= 1'b1;
`endif
                        end else begin
                            cnt_r      <= cnt_r + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_LOAD_C: begin
`ifdef SERIAL_CIN_LOAD_EN
                    if (bus.sdata_valid) begin
                        cin_r      <= bus.sdata;
                        state_r    <= ST_PRESENT;
                        op_valid_r <= 1'b1;
                    end
`else
                    state_r    <= ST_IDLE;
                    op_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
`endif
                end
                ST_PRESENT: begin
                    if (bus.op_ack) begin
                        state_r    <= ST_IDLE;
                        op_valid_r <= 1'b0;
                        busy_r     <= state_is_busy(ST_IDLE);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= '0;
                    op_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cin      = cin_r;
    assign bus.op_valid = op_valid_r;
    assign bus.busy     = busy_r;

endmodule
